// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM UDP control path: counter width, frame magic,
// FSM state encoding and frame-word packing helpers.
package pwm_pkg;

  localparam int         PWM_CNT_W     = 28;
  localparam logic [7:0] PWM_HDR_MAGIC = 8'hA5;
  // Wide enough to hold CHANNEL_NUM itself (up to 32) as a "past the end" index.
  localparam int         PWM_IDX_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CH_A = 3'd2,
    ST_CH_B = 3'd3,
    ST_CSUM = 3'd4
  } pwm_state_e;

  function automatic logic [31:0] pwm_hdr_word(input logic [7:0] ftype,
                                               input logic [7:0] nch,
                                               input logic [7:0] seq);
    return {PWM_HDR_MAGIC, ftype, nch, seq};
  endfunction

  function automatic logic [31:0] pwm_word_a(input logic                 en,
                                             input logic [PWM_CNT_W-1:0] period);
    return {en, 3'b000, period};
  endfunction

  function automatic logic [31:0] pwm_word_b(input logic [PWM_CNT_W-1:0] hlevel);
    return {4'h0, hlevel};
  endfunction

endpackage

// File: rtl/pwm_status_snap.sv
// Snapshot registers for every channel's live PWM config, plus a mux that
// presents the channel selected by idx (all-zero when idx is out of range).
module pwm_status_snap
  import pwm_pkg::*;
#(
  parameter int CHANNEL_NUM = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             capture,
  input  logic [CHANNEL_NUM-1:0]           ch_en,
  input  logic [PWM_CNT_W*CHANNEL_NUM-1:0] ch_period,
  input  logic [PWM_CNT_W*CHANNEL_NUM-1:0] ch_hlevel,
  input  logic [PWM_IDX_W-1:0]             idx,
  output logic                             sel_en,
  output logic [PWM_CNT_W-1:0]             sel_period,
  output logic [PWM_CNT_W-1:0]             sel_hlevel
);

  logic                 en_r     [CHANNEL_NUM];
  logic [PWM_CNT_W-1:0] period_r [CHANNEL_NUM];
  logic [PWM_CNT_W-1:0] hlevel_r [CHANNEL_NUM];

  // Capture all channels together so the frame reflects one instant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        en_r[i]     <= 1'b0;
        period_r[i] <= '0;
        hlevel_r[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        en_r[i]     <= ch_en[i];
        period_r[i] <= ch_period[PWM_CNT_W*i +: PWM_CNT_W];
        hlevel_r[i] <= ch_hlevel[PWM_CNT_W*i +: PWM_CNT_W];
      end
    end
  end

  // AND-OR select keyed on idx; an index past the last channel yields zero.
  always_comb begin
    sel_en     = 1'b0;
    sel_period = '0;
    sel_hlevel = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      sel_en     = sel_en     | (en_r[i] & (idx == PWM_IDX_W'(i)));
      sel_period = sel_period | (period_r[i] & {PWM_CNT_W{idx == PWM_IDX_W'(i)}});
      sel_hlevel = sel_hlevel | (hlevel_r[i] & {PWM_CNT_W{idx == PWM_IDX_W'(i)}});
    end
  end

endmodule

// File: rtl/pwm_status_tx.sv
// PWM status readback: snapshots every channel's config on request and streams
// it as a 32-bit UDP user frame. Define PWM_STATUS_CSUM_EN to append an XOR word.
module pwm_status_tx
  import pwm_pkg::*;
#(
  parameter int   CHANNEL_NUM    = 8,
  parameter int   PWM_PARAM_TYPE = 0,
  parameter logic FRAME_TUSER    = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             report_req,
  input  logic [CHANNEL_NUM-1:0]           ch_en,
  input  logic [PWM_CNT_W*CHANNEL_NUM-1:0] ch_period,
  input  logic [PWM_CNT_W*CHANNEL_NUM-1:0] ch_hlevel,
  output logic [31:0]                      tx_axis_udp_tdata,
  output logic                             tx_axis_udp_tvalid,
  input  logic                             tx_axis_udp_tready,
  output logic                             tx_axis_udp_tlast,
  output logic                             tx_axis_udp_tuser,
  output logic                             busy
);

  localparam logic [7:0]           FTYPE   = 8'(PWM_PARAM_TYPE);
  localparam logic [7:0]           NCH     = 8'(CHANNEL_NUM);
  localparam logic [PWM_IDX_W-1:0] IDX_END = PWM_IDX_W'(CHANNEL_NUM);
  localparam logic [PWM_IDX_W-1:0] IDX_LST = PWM_IDX_W'(CHANNEL_NUM - 1);

  pwm_state_e           state_r, n_state_s;
  logic [PWM_IDX_W-1:0] ch_idx_r, n_ch_idx_s;
  logic [7:0]           seq_r, n_seq_s;
  logic                 pending_r, n_pending_s;
  logic [31:0]          tdata_r, n_tdata_s;
  logic                 tvalid_r, n_tvalid_s;
  logic                 tlast_r, n_tlast_s;
  logic                 tuser_r, n_tuser_s;
  logic                 busy_r, n_busy_s;
  logic                 capture_s;
  logic                 accept_s, last_s;
  logic                 sel_en_s;
  logic [PWM_CNT_W-1:0] sel_period_s, sel_hlevel_s;
`ifdef PWM_STATUS_CSUM_EN
  logic [31:0]          csum_r, n_csum_s;
`endif

  pwm_status_snap #(.CHANNEL_NUM(CHANNEL_NUM)) u_snap (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (capture_s),
    .ch_en      (ch_en),
    .ch_period  (ch_period),
    .ch_hlevel  (ch_hlevel),
    .idx        (ch_idx_r),
    .sel_en     (sel_en_s),
    .sel_period (sel_period_s),
    .sel_hlevel (sel_hlevel_s)
  );

  assign accept_s = tvalid_r & tx_axis_udp_tready;
  assign last_s   = accept_s & tlast_r;

  // Next-state and next-word logic; every output word is registered.
  always_comb begin
    n_state_s   = state_r;
    n_ch_idx_s  = ch_idx_r;
    n_seq_s     = seq_r;
    n_pending_s = pending_r;
    n_tdata_s   = tdata_r;
    n_tvalid_s  = tvalid_r;
    n_tlast_s   = tlast_r;
    n_tuser_s   = tuser_r;
    n_busy_s    = busy_r;
    capture_s   = 1'b0;
`ifdef PWM_STATUS_CSUM_EN
    n_csum_s    = csum_r;
`endif
    if (last_s) begin
      n_seq_s     = seq_r + 8'd1;
      n_pending_s = 1'b0;
      // A request seen now or earlier in the frame starts the next one back-to-back.
      if (pending_r || report_req) begin
        capture_s  = 1'b1;
        n_state_s  = ST_HDR;
        n_ch_idx_s = '0;
        n_tdata_s  = pwm_hdr_word(FTYPE, NCH, seq_r + 8'd1);
        n_tvalid_s = 1'b1;
        n_tlast_s  = 1'b0;
        n_tuser_s  = FRAME_TUSER;
        n_busy_s   = 1'b1;
`ifdef PWM_STATUS_CSUM_EN
        n_csum_s   = pwm_hdr_word(FTYPE, NCH, seq_r + 8'd1);
`endif
      end else begin
        n_state_s  = ST_IDLE;
        n_ch_idx_s = '0;
        n_tdata_s  = 32'h0000_0000;
        n_tvalid_s = 1'b0;
        n_tlast_s  = 1'b0;
        n_tuser_s  = 1'b0;
        n_busy_s   = 1'b0;
      end
    end else begin
      if (report_req && (state_r != ST_IDLE)) begin
        n_pending_s = 1'b1;
      end else begin
        n_pending_s = pending_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (report_req) begin
            capture_s  = 1'b1;
            n_state_s  = ST_HDR;
            n_ch_idx_s = '0;
            n_tdata_s  = pwm_hdr_word(FTYPE, NCH, seq_r);
            n_tvalid_s = 1'b1;
            n_tlast_s  = 1'b0;
            n_tuser_s  = FRAME_TUSER;
            n_busy_s   = 1'b1;
`ifdef PWM_STATUS_CSUM_EN
            n_csum_s   = pwm_hdr_word(FTYPE, NCH, seq_r);
`endif
          end else begin
            n_state_s = ST_IDLE;
          end
        end
        ST_HDR: begin
          if (accept_s) begin
            n_state_s = ST_CH_A;
            n_tdata_s = pwm_word_a(sel_en_s, sel_period_s);
            n_tlast_s = 1'b0;
`ifdef PWM_STATUS_CSUM_EN
            n_csum_s  = csum_r ^ pwm_word_a(sel_en_s, sel_period_s);
`endif
          end else begin
            n_state_s = ST_HDR;
          end
        end
        ST_CH_A: begin
          // Index steps here so that CH_B already selects the next channel's A word.
          if (accept_s) begin
            n_state_s  = ST_CH_B;
            n_ch_idx_s = ch_idx_r + PWM_IDX_W'(1);
            n_tdata_s  = pwm_word_b(sel_hlevel_s);
`ifdef PWM_STATUS_CSUM_EN
            n_tlast_s  = 1'b0;
            n_csum_s   = csum_r ^ pwm_word_b(sel_hlevel_s);
`else
            n_tlast_s  = (ch_idx_r == IDX_LST);
`endif
          end else begin
            n_state_s = ST_CH_A;
          end
        end
        ST_CH_B: begin
          if (accept_s) begin
`ifdef PWM_STATUS_CSUM_EN
            if (ch_idx_r == IDX_END) begin
              n_state_s = ST_CSUM;
              n_tdata_s = csum_r;
              n_tlast_s = 1'b1;
            end else begin
              n_state_s = ST_CH_A;
              n_tdata_s = pwm_word_a(sel_en_s, sel_period_s);
              n_tlast_s = 1'b0;
              n_csum_s  = csum_r ^ pwm_word_a(sel_en_s, sel_period_s);
            end
`else
            n_state_s = ST_CH_A;
            n_tdata_s = pwm_word_a(sel_en_s, sel_period_s);
            n_tlast_s = 1'b0;
`endif
          end else begin
            n_state_s = ST_CH_B;
          end
        end
        default: begin
          n_state_s = state_r;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ch_idx_r  <= '0;
      seq_r     <= 8'd0;
      pending_r <= 1'b0;
      tdata_r   <= 32'h0000_0000;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      tuser_r   <= 1'b0;
      busy_r    <= 1'b0;
`ifdef PWM_STATUS_CSUM_EN
      csum_r    <= 32'h0000_0000;
`endif
    end else begin
      state_r   <= n_state_s;
      ch_idx_r  <= n_ch_idx_s;
      seq_r     <= n_seq_s;
      pending_r <= n_pending_s;
      tdata_r   <= n_tdata_s;
      tvalid_r  <= n_tvalid_s;
      tlast_r   <= n_tlast_s;
      tuser_r   <= n_tuser_s;
      busy_r    <= n_busy_s;
`ifdef PWM_STATUS_CSUM_EN
      csum_r    <= n_csum_s;
`endif
    end
  end

  assign tx_axis_udp_tdata  = tdata_r;
  assign tx_axis_udp_tvalid = tvalid_r;
  assign tx_axis_udp_tlast  = tlast_r;
  assign tx_axis_udp_tuser  = tuser_r;
  assign busy               = busy_r;

endmodule
